// File: rtl/outputc_pkg.sv
// outputc_pkg: shared widths, flit-type encoding and lock-state type for the output controller.
package outputc_pkg;
  localparam int DATAW = 31;
  localparam int VCH = 1;
  localparam int VCHW = 0;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;
  localparam int OC_BUFDEPTH = 4;
  typedef enum logic [1:0] {
    TYPE_BODY = 2'd0,
    TYPE_HEAD = 2'd1,
    TYPE_TAIL = 2'd2,
    TYPE_HEADTAIL = 2'd3
  } flit_type_e;
  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} lck_state_e;
endpackage

// File: rtl/outputc_credit_cnt.sv
// outputc_credit_cnt: one VC's downstream credit counter with saturation, ready decode and error pulse.
module outputc_credit_cnt #(
  parameter int BUFDEPTH = 4,
  parameter int CNTW = 2
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_dec,
  input  logic i_inc,
  output logic o_rdy,
  output logic o_err
);
  localparam logic [CNTW:0] FULL = (CNTW+1)'(BUFDEPTH);
  logic [CNTW:0] r_cnt, w_nxt;
  always_comb begin
    w_nxt = i_dec == i_inc ? r_cnt
          : i_dec ? (r_cnt == '0 ? r_cnt : r_cnt - 1'b1)
          : (r_cnt == FULL ? r_cnt : r_cnt + 1'b1);
    o_err = (i_dec && r_cnt == '0) || (i_inc && !i_dec && r_cnt == FULL);
  end
  assign o_rdy = r_cnt != '0;
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) r_cnt <= FULL;
    else r_cnt <= w_nxt;
  end
endmodule

// File: rtl/outputc.sv
// outputc: registers crossbar flits onto the link, tracks per-VC credits and per-VC packet locks.
module outputc
  import outputc_pkg::*;
#(
  parameter int BUFDEPTH = OC_BUFDEPTH,
  parameter int CNTW = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   idata,
  input  logic             ivalid,
  input  logic [VCHW:0]    ivch,
  input  logic [VCH:0]     iack,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch,
  output logic [VCH:0]     ordy,
  output logic [VCH:0]     olck,
  output logic             err
);
  logic [DATAW:0] r_odata;
  logic           r_ovalid;
  logic [VCHW:0]  r_ovch;
  logic           r_err;
  logic [VCH:0]   w_acc, w_cerr, w_ferr;
  lck_state_e     r_state [VCH:0];
  lck_state_e     w_state_nxt [VCH:0];
  flit_type_e     w_type;
  assign w_type = flit_type_e'(idata[TYPE_MSB:TYPE_LSB]);
  for (genvar v = 0; v <= VCH; v++) begin : g_vc
    assign w_acc[v] = ivalid && ivch == (VCHW+1)'(v);
    outputc_credit_cnt #(.BUFDEPTH(BUFDEPTH), .CNTW(CNTW)) u_cnt (
      .clk(clk), .rst_(rst_), .i_dec(w_acc[v]), .i_inc(iack[v]),
      .o_rdy(ordy[v]), .o_err(w_cerr[v])
    );
  end
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) for (int v = 0; v <= VCH; v++) r_state[v] <= FREE;
    else for (int v = 0; v <= VCH; v++) r_state[v] <= w_state_nxt[v];
  end
  // A packet-start flit is legal only when FREE, any other flit only when LOCKED.
  always_comb begin
    for (int v = 0; v <= VCH; v++) begin
      w_ferr[v] = w_acc[v] && ((r_state[v] == LOCKED) == (w_type == TYPE_HEAD || w_type == TYPE_HEADTAIL));
      w_state_nxt[v] = !w_acc[v] || w_ferr[v] ? r_state[v]
                     : w_type == TYPE_HEAD ? LOCKED
                     : w_type == TYPE_TAIL ? FREE : r_state[v];
    end
  end
  always_comb begin
    for (int v = 0; v <= VCH; v++) olck[v] = r_state[v] == LOCKED;
  end
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_odata <= '0;
      r_ovalid <= 1'b0;
      r_ovch <= '0;
      r_err <= 1'b0;
    end else begin
      r_odata <= ivalid ? idata : '0;
      r_ovalid <= ivalid;
      r_ovch <= ivalid ? ivch : '0;
      r_err <= r_err | (|w_cerr) | (|w_ferr);
    end
  end
  assign odata = r_odata;
  assign ovalid = r_ovalid;
  assign ovch = r_ovch;
  assign err = r_err;
endmodule

// File: tb/tb_outputc.sv
// tb_outputc: directed checks of forwarding, credit counting and lock tracking in outputc.
module tb_outputc;
  import outputc_pkg::*;
  logic clk = 1'b0, rst_ = 1'b0, ivalid = 1'b0;
  logic [31:0] idata = '0;
  logic [0:0] ivch = '0;
  logic [1:0] iack = '0;
  logic [31:0] odata;
  logic ovalid, err;
  logic [0:0] ovch;
  logic [1:0] ordy, olck;
  int n = 0, nf = 0;
  outputc dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .iack(iack),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .ordy(ordy), .olck(olck), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] fl(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic c, input logic [1:0] a);
    ivalid = v; idata = d; ivch = c; iack = a;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    #1 rst_ = 1'b1;
    #1 rst_ = 1'b0;
  endtask
  initial begin
    #2 rst_ = 1'b1;
    #1;
    chk("rst_odata", odata, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_ordy", ordy, 2'b11);
    chk("rst_olck", olck, 0);
    chk("rst_err", err, 0);
    rst_ = 1'b0;
    step(1, fl(TYPE_HEAD, 30'h0A), 0, 0);
    chk("head_odata", odata, fl(TYPE_HEAD, 30'h0A));
    chk("head_ovalid", ovalid, 1);
    chk("head_ovch", ovch, 0);
    chk("head_ordy", ordy, 2'b11);
    chk("head_olck", olck, 2'b01);
    step(1, fl(TYPE_BODY, 30'h0B), 0, 0);
    chk("body1_odata", odata, fl(TYPE_BODY, 30'h0B));
    chk("body1_ordy", ordy, 2'b11);
    chk("body1_olck", olck, 2'b01);
    step(1, fl(TYPE_BODY, 30'h0C), 0, 0);
    chk("body2_ordy", ordy, 2'b11);
    step(1, fl(TYPE_TAIL, 30'h0D), 0, 0);
    chk("tail_odata", odata, fl(TYPE_TAIL, 30'h0D));
    chk("tail_ordy", ordy, 2'b10);
    chk("tail_olck", olck, 2'b00);
    chk("tail_err", err, 0);
    step(0, 32'hFFFF_FFFF, 0, 0);
    chk("idle_odata", odata, 0);
    chk("idle_ovalid", ovalid, 0);
    step(0, 0, 0, 2'b01);
    chk("ack_ordy", ordy, 2'b11);
    step(0, 0, 0, 2'b01);
    step(1, fl(TYPE_HEADTAIL, 30'h11), 0, 2'b01);
    chk("ht_olck", olck, 2'b00);
    chk("accack_err", err, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h12), 0, 0);
    chk("cnt2_a_ordy", ordy, 2'b11);
    step(1, fl(TYPE_HEADTAIL, 30'h13), 0, 0);
    chk("cnt2_b_ordy", ordy, 2'b10);
    chk("cnt2_err", err, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h55), 0, 0);
    chk("ovf_odata", odata, fl(TYPE_HEADTAIL, 30'h55));
    chk("ovf_ovalid", ovalid, 1);
    chk("ovf_err", err, 1);
    chk("ovf_ordy", ordy, 2'b10);
    step(1, fl(TYPE_HEAD, 30'h21), 1, 0);
    chk("vc1_ovch", ovch, 1);
    chk("vc1_olck", olck, 2'b10);
    chk("sticky_err", err, 1);
    #1 rst_ = 1'b1;
    #1;
    chk("arst_odata", odata, 0);
    chk("arst_ovalid", ovalid, 0);
    chk("arst_ovch", ovch, 0);
    chk("arst_ordy", ordy, 2'b11);
    chk("arst_olck", olck, 2'b00);
    chk("arst_err", err, 0);
    rst_ = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_ovalid", ovalid, 0);
    chk("post_rst_olck", olck, 2'b00);
    step(0, 0, 0, 2'b01);
    chk("sat_err", err, 1);
    chk("sat_ordy", ordy, 2'b11);
    step(1, fl(TYPE_HEADTAIL, 30'h1), 0, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h2), 0, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h3), 0, 0);
    chk("sat_cnt_a", ordy, 2'b11);
    step(1, fl(TYPE_HEADTAIL, 30'h4), 0, 0);
    chk("sat_cnt_b", ordy, 2'b10);
    pulse_rst();
    step(1, fl(TYPE_HEAD, 30'h31), 0, 0);
    chk("hh1_err", err, 0);
    step(1, fl(TYPE_HEAD, 30'h32), 0, 0);
    chk("hh2_err", err, 1);
    chk("hh2_olck", olck, 2'b01);
    pulse_rst();
    step(1, fl(TYPE_BODY, 30'h41), 1, 0);
    chk("bfree_err", err, 1);
    chk("bfree_olck", olck, 2'b00);
    pulse_rst();
    step(1, fl(TYPE_HEADTAIL, 30'h51), 0, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h52), 1, 0);
    step(0, 0, 0, 2'b11);
    chk("ack2_err", err, 0);
    step(0, 0, 0, 2'b01);
    chk("ack2_vc0_full", err, 1);
    pulse_rst();
    step(1, fl(TYPE_HEADTAIL, 30'h61), 0, 0);
    step(1, fl(TYPE_HEADTAIL, 30'h62), 1, 0);
    step(0, 0, 0, 2'b11);
    step(0, 0, 0, 2'b10);
    chk("ack2_vc1_full", err, 1);
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
